// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Raster timing record, standard mode presets, total helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_active;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_front: 16, h_sync: 96,  h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,   v_back: 33
    };

    localparam vga_timing_t VGA_800X600_60 = '{
        h_active: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_active: 600, v_front: 1,  v_sync: 4,   v_back: 23
    };

    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_div
// Description : Divides the system clock into a one-cycle-wide enable pulse
//               every CLK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    if (CLK_DIV == 1) begin : g_passthru
        // Every cycle is a pixel; clock and reset are not needed.
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_tick   = 1'b1;
    end else begin : g_count
        localparam int              c_DW   = $clog2(CLK_DIV);
        localparam logic [c_DW-1:0] c_LAST = c_DW'(CLK_DIV - 1);

        logic [c_DW-1:0] r_div_cnt;

        always_ff @(posedge clk) begin
            if (rst || (r_div_cnt == c_LAST)) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end

        assign o_tick = (r_div_cnt == c_LAST);
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator: pixel enable, x/y
//               counters, registered sync/blanking and line/frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_ACTIVE  = int'(VGA_640X480_60.h_active),
    parameter int H_FRONT   = int'(VGA_640X480_60.h_front),
    parameter int H_SYNC    = int'(VGA_640X480_60.h_sync),
    parameter int H_BACK    = int'(VGA_640X480_60.h_back),
    parameter int V_ACTIVE  = int'(VGA_640X480_60.v_active),
    parameter int V_FRONT   = int'(VGA_640X480_60.v_front),
    parameter int V_SYNC    = int'(VGA_640X480_60.v_sync),
    parameter int V_BACK    = int'(VGA_640X480_60.v_back),
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 11
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = int'(vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
    localparam int V_TOTAL = int'(vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));

    localparam logic [CW-1:0] c_H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACTIVE   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACTIVE   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_FIRST   = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] c_HS_LAST    = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] c_VS_FIRST   = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] c_VS_LAST    = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if ((H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
        (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_chk_widths
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end
    if (((64'd1 << CW) < 64'(H_TOTAL)) || ((64'd1 << CW) < 64'(V_TOTAL))) begin : g_chk_cw
        $error("vga_timing_gen: CW too narrow for the line or frame total");
    end

    logic          w_tick;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic          w_vid_nxt;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          r_video_on;
    logic          r_hsync;
    logic          r_vsync;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk_100MHz),
        .rst    (reset),
        .o_tick (w_tick)
    );

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_tick) begin
            if (r_x == c_H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end
    end

    // Decoding the next position lets the registered flags line up with x/y.
    always_comb begin
        w_vid_nxt = (w_x_nxt < c_H_ACTIVE) && (w_y_nxt < c_V_ACTIVE);
        w_hs_act  = (w_x_nxt >= c_HS_FIRST) && (w_x_nxt <= c_HS_LAST);
        w_vs_act  = (w_y_nxt >= c_VS_FIRST) && (w_y_nxt <= c_VS_LAST);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_video_on <= 1'b1;
            r_hsync    <= ~HSYNC_POL;
            r_vsync    <= ~VSYNC_POL;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_video_on <= w_vid_nxt;
            r_hsync    <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync    <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign p_tick      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = w_tick && (r_x == '0);
    assign frame_start = w_tick && (r_x == '0) && (r_y == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen over three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CW = 11;

    typedef struct packed {
        logic          p_tick;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          video_on;
        logic          hsync;
        logic          vsync;
        logic          line_start;
        logic          frame_start;
    } obs_t;

    // 800-wide horizontal timing with a short frame so several frames fit.
    localparam vga_timing_t T_WIDE = '{
        h_active: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_active: 3,   v_front: 1,  v_sync: 1,   v_back: 1
    };
    localparam vga_timing_t T_TINY = '{
        h_active: 4, h_front: 1, h_sync: 1, h_back: 1,
        v_active: 2, v_front: 1, v_sync: 1, v_back: 1
    };

    logic       clk_100MHz;
    logic [2:0] rst_v;
    int         n_checks = 0;
    int         n_errs   = 0;

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // Position is derived from elapsed clocks since reset, not from counters.
    function automatic obs_t model(input int n, input int d, input vga_timing_t t, input bit pol);
        obs_t o;
        int   ht, vt, p, px, py, hs0, vs0;
        ht  = int'(t.h_active + t.h_front + t.h_sync + t.h_back);
        vt  = int'(t.v_active + t.v_front + t.v_sync + t.v_back);
        hs0 = int'(t.h_active + t.h_front);
        vs0 = int'(t.v_active + t.v_front);
        p   = n / d;
        px  = p % ht;
        py  = (p / ht) % vt;
        o.p_tick      = ((n % d) == (d - 1));
        o.x           = CW'(px);
        o.y           = CW'(py);
        o.video_on    = (px < int'(t.h_active)) && (py < int'(t.v_active));
        o.hsync       = ((px >= hs0) && (px < hs0 + int'(t.h_sync))) ? pol : ~pol;
        o.vsync       = ((py >= vs0) && (py < vs0 + int'(t.v_sync))) ? pol : ~pol;
        o.line_start  = o.p_tick && (px == 0);
        o.frame_start = o.line_start && (py == 0);
        return o;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int          D  = (g == 0) ? 4 : (g == 1) ? 1 : 3;
        localparam bit          HP = (g == 1);
        localparam vga_timing_t T  = (g == 0) ? VGA_640X480_60 : (g == 1) ? T_WIDE : T_TINY;

        logic          p_tick, video_on, hsync, vsync, line_start, frame_start;
        logic [CW-1:0] x, y;
        obs_t          exp_q[$];
        int            n      = 0;
        int            frames = 0;

        vga_timing_gen #(
            .CLK_DIV   (D),
            .H_ACTIVE  (int'(T.h_active)),
            .H_FRONT   (int'(T.h_front)),
            .H_SYNC    (int'(T.h_sync)),
            .H_BACK    (int'(T.h_back)),
            .V_ACTIVE  (int'(T.v_active)),
            .V_FRONT   (int'(T.v_front)),
            .V_SYNC    (int'(T.v_sync)),
            .V_BACK    (int'(T.v_back)),
            .HSYNC_POL (HP),
            .VSYNC_POL (HP),
            .CW        (CW)
        ) u_dut (
            .clk_100MHz  (clk_100MHz),
            .reset       (rst_v[g]),
            .p_tick      (p_tick),
            .x           (x),
            .y           (y),
            .video_on    (video_on),
            .hsync       (hsync),
            .vsync       (vsync),
            .line_start  (line_start),
            .frame_start (frame_start)
        );

        always @(posedge clk_100MHz) begin
            n = rst_v[g] ? 0 : n + 1;
            exp_q.push_back(model(n, D, T, HP));
        end

        always @(negedge clk_100MHz) begin
            obs_t a, e;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {p_tick, x, y, video_on, hsync, vsync, line_start, frame_start};
                if (frame_start) frames++;
                n_checks++;
                if (a !== e) begin
                    n_errs++;
                    $display("FAIL cfg%0d_outputs n=%0d: actual tick=%b x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b required tick=%b x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b",
                             g, n, a.p_tick, a.x, a.y, a.video_on, a.hsync, a.vsync, a.line_start, a.frame_start,
                             e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.line_start, e.frame_start);
                end
                n_checks++;
                if ((line_start || frame_start) && !p_tick) begin
                    n_errs++;
                    $display("FAIL cfg%0d_strobe_without_tick n=%0d: actual ls=%b fs=%b tick=%b required no strobe",
                             g, n, line_start, frame_start, p_tick);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errs++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    initial begin
        int k, lo, rst_a_at;
        rst_v = 3'b111;
        repeat (5) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        chk("reset_x",            int'(g_cfg[0].x), 0);
        chk("reset_y",            int'(g_cfg[0].y), 0);
        chk("reset_video_on",     int'(g_cfg[0].video_on), 1);
        chk("reset_hsync",        int'(g_cfg[0].hsync), 1);
        chk("reset_vsync",        int'(g_cfg[0].vsync), 1);
        chk("reset_p_tick",       int'(g_cfg[0].p_tick), 0);
        chk("reset_line_start",   int'(g_cfg[0].line_start), 0);
        chk("div1_reset_hsync",   int'(g_cfg[1].hsync), 0);
        chk("div1_frame_start",   int'(g_cfg[1].frame_start), 1);

        rst_v = 3'b000;
        k = 0;
        do begin @(negedge clk_100MHz); k++; end while (!g_cfg[0].p_tick && k < 20);
        chk("first_tick_latency", k, 3);
        chk("first_tick_x",       int'(g_cfg[0].x), 0);
        k = 0;
        do begin @(negedge clk_100MHz); k++; end while (!g_cfg[0].p_tick && k < 20);
        chk("tick_period", k, 4);
        chk("first_advance_x", int'(g_cfg[0].x), 1);

        k = 0;
        do begin @(negedge clk_100MHz); k++; end while (!g_cfg[0].line_start && k < 5000);
        chk("second_line_start_y", int'(g_cfg[0].y), 1);
        k  = 0;
        lo = 0;
        do begin
            @(negedge clk_100MHz);
            k++;
            if (!g_cfg[0].hsync) lo++;
        end while (!g_cfg[0].line_start && k < 5000);
        chk("line_period_clocks", k, 3200);
        chk("hsync_low_clocks",   lo, 384);

        rst_a_at = int'($urandom_range(6000, 9000));
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk_100MHz);
            rst_v[0] = (c == rst_a_at);
            rst_v[2] = ($urandom_range(0, 399) == 0);
        end
        rst_v = 3'b000;
        repeat (4) @(negedge clk_100MHz);
        chk("wide_frames_seen", int'(g_cfg[1].frames >= 3), 1);
        chk("tiny_frames_seen", int'(g_cfg[2].frames >= 3), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
